// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock divider: default sizing and the
// encoding of the output-select input.
package clk_div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32'd8;
  localparam int unsigned DEFAULT_DIV   = 32'd255;

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PULSE  = 1'b1
  } out_mode_e;

endpackage

// File: rtl/prog_clk_div_if.sv
// Control and status bundle of the programmable clock divider.
interface prog_clk_div_if
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] div_in;
  logic             pulse_mode;
  logic             tick;
  logic             o;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] div_q;

  modport master (
    output en, load, div_in, pulse_mode,
    input  tick, o, count, div_q
  );

  modport slave (
    input  en, load, div_in, pulse_mode,
    output tick, o, count, div_q
  );

endinterface

// File: rtl/div_counter.sv
// Enabled up-counter that wraps to zero when it reaches the active divisor;
// tc flags the terminal count combinationally for the owning register stage.
module div_counter
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_r;

  // Terminal count compare against the active divisor
  assign tc  = (cnt_r == div);
  assign cnt = cnt_r;

  // Count register: only the terminal compare may return it to zero while counting
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (load) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (en) begin
      if (tc) begin
        cnt_r <= {WIDTH{1'b0}};
      end else begin
        cnt_r <= cnt_r + WIDTH'(1'b1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/prog_clk_div.sv
// Programmable clock divider: tick every D+1 enabled cycles and a 50% square
// wave of period 2(D+1); o selects between them without touching any state.
module prog_clk_div
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH       = clk_div_pkg::DEFAULT_WIDTH,
  parameter int unsigned DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
  input  logic           clk,
  input  logic           reset,
  prog_clk_div_if.slave  bus
);

  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             sq;
  logic             tick_r;
  logic             o_s;

  div_counter #(
    .WIDTH (WIDTH)
  ) u_div_counter (
    .clk   (clk),
    .reset (reset),
    .en    (bus.en),
    .load  (bus.load),
    .div   (div_reg),
    .cnt   (cnt),
    .tc    (tc)
  );

  // Divisor, square-wave and tick registers; load leaves the square phase alone
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_reg <= WIDTH'(DEFAULT_DIV);
      sq      <= 1'b0;
      tick_r  <= 1'b0;
    end else if (bus.load) begin
      div_reg <= bus.div_in;
      sq      <= sq;
      tick_r  <= 1'b0;
    end else if (bus.en) begin
      div_reg <= div_reg;
      sq      <= sq ^ tc;
      tick_r  <= tc;
    end else begin
      div_reg <= div_reg;
      sq      <= sq;
      tick_r  <= 1'b0;
    end
  end

  // Output select: the only non-registered output, a single mux of two flops
  always_comb begin
    o_s = sq;
    if (bus.pulse_mode == MODE_PULSE) begin
      o_s = tick_r;
    end else begin
      o_s = sq;
    end
  end

  assign bus.o     = o_s;
  assign bus.tick  = tick_r;
  assign bus.count = cnt;
  assign bus.div_q = div_reg;

endmodule

// File: tb/tb_prog_clk_div.sv
// Randomised and directed bench for prog_clk_div, compared every cycle against
// an enabled-edge-count reference model.
module tb_prog_clk_div;

  logic  clk   = 1'b0;
  logic  reset = 1'b0;
  int    errors = 0;
  int    checks = 0;
  string phase  = "init";

  // reference model: enabled edges since restart, divisor, ticks since reset
  int    m_n     = 0;
  int    m_div   = 255;
  int    m_ticks = 0;
  bit    m_tick  = 1'b0;

  prog_clk_div_if #(.WIDTH(8)) bus ();

  prog_clk_div #(
    .WIDTH       (8),
    .DEFAULT_DIV (255)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r, input bit l, input bit e, input int d, input bit pm);
    reset          = r;
    bus.load       = l;
    bus.en         = e;
    bus.div_in     = d[7:0];
    bus.pulse_mode = pm;
  endtask

  task automatic model_edge();
    if (!reset) begin
      m_n = 0; m_div = 255; m_ticks = 0; m_tick = 1'b0;
    end else if (bus.load) begin
      m_div = int'(bus.div_in); m_n = 0; m_tick = 1'b0;
    end else if (bus.en) begin
      m_n++;
      m_tick = ((m_n % (m_div + 1)) == 0);
      if (m_tick) m_ticks++;
    end else begin
      m_tick = 1'b0;
    end
  endtask

  task automatic compare_all();
    bit exp_sq;
    exp_sq = (m_ticks % 2) == 1;
    check({phase, ".count"}, 32'(bus.count), 32'(m_n % (m_div + 1)));
    check({phase, ".div_q"}, 32'(bus.div_q), 32'(m_div));
    check({phase, ".tick"},  32'(bus.tick),  32'(m_tick));
    check({phase, ".o"},     32'(bus.o),     32'(bus.pulse_mode ? m_tick : exp_sq));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);

    phase = "reset_default";
    run(2);
    drive(1'b1, 1'b0, 1'b1, 0, 1'b0);
    run(1100);

    phase = "load4";
    drive(1'b1, 1'b1, 1'b0, 4, 1'b0);
    run(1);
    drive(1'b1, 1'b0, 1'b1, 0, 1'b0);
    run(20);

    phase = "div0";
    drive(1'b1, 1'b1, 1'b1, 0, 1'b1);
    run(1);
    drive(1'b1, 1'b0, 1'b1, 0, 1'b1);
    run(10);
    bus.pulse_mode = 1'b0;
    run(4);

    phase = "en_gate";
    drive(1'b1, 1'b1, 1'b0, 3, 1'b0);
    run(1);
    bus.load = 1'b0; bus.en = 1'b1;
    run(2);
    bus.en = 1'b0;
    run(5);
    bus.en = 1'b1;
    run(6);

    phase = "mid_reset";
    drive(1'b1, 1'b1, 1'b0, 9, 1'b0);
    run(1);
    bus.load = 1'b0; bus.en = 1'b1;
    run(7);
    drive(1'b0, 1'b1, 1'b1, 5, 1'b0);
    run(1);
    drive(1'b1, 1'b0, 1'b1, 0, 1'b0);
    run(15);

    phase = "mid_load";
    drive(1'b1, 1'b1, 1'b0, 9, 1'b0);
    run(1);
    bus.load = 1'b0; bus.en = 1'b1;
    run(6);
    drive(1'b1, 1'b1, 1'b1, 2, 1'b1);
    run(1);
    drive(1'b1, 1'b0, 1'b1, 0, 1'b1);
    run(12);

    // reset pulses that start and end between edges must not be seen
    phase = "sync_reset";
    for (int i = 0; i < 3; i++) begin
      reset = 1'b0;
      #3;
      reset = 1'b1;
      step();
    end

    phase = "random";
    for (int i = 0; i < 4000; i++) begin
      int d;
      d = ($urandom_range(3) == 0) ? int'($urandom_range(255)) : int'($urandom_range(7));
      drive($urandom_range(99) != 0, $urandom_range(39) == 0,
            $urandom_range(3) != 0, d, $urandom_range(1) == 1);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
